// File: rtl/vga_fb_scan_if.sv
// Plot-write and scanout bus for vga_fb_scan. The slave modport is the
// framebuffer side; the master modport is the plotter/display side.
interface vga_fb_scan_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic [2:0] pix_colour;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_valid;
    logic       pix_ready;

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, pix_ready,
        output pix_colour, pix_x, pix_y, pix_sof, pix_eol, pix_valid
    );

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, pix_ready,
        input  pix_colour, pix_x, pix_y, pix_sof, pix_eol, pix_valid
    );
endinterface

// File: rtl/vga_fb_scan.sv
// Framebuffer with clear engine, plot write port and raster scanout stream.
// Optional VGA_FB_DROP_CNT_EN adds a saturating count of dropped plots.
module vga_fb_scan #(
    parameter int         FB_W       = 160,
    parameter int         FB_H       = 120,
    parameter logic [2:0] CLR_COLOUR = 3'b000
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_fb_scan_if.slave       bus,
    input  logic               clear,
    output logic               busy
`ifdef VGA_FB_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);
    localparam int         NPIX      = FB_W * FB_H;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [7:0]  X_LAST    = 8'(FB_W - 1);
    localparam logic [6:0]  Y_LAST    = 7'(FB_H - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    logic [2:0] mem [NPIX];

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic [7:0]  rx_q, rx_d;
    logic [6:0]  ry_q, ry_d;
    logic [14:0] raddr_q, raddr_d;
    logic        pix_valid_q, pix_valid_d;
    logic [7:0]  pix_x_q, pix_x_d;
    logic [6:0]  pix_y_q, pix_y_d;
    logic        pix_sof_q, pix_sof_d;
    logic        pix_eol_q, pix_eol_d;
    logic [2:0]  pix_colour_q;

    logic        we;
    logic [14:0] wa;
    logic [2:0]  wd;
    logic        load;
    logic        plot_ok;
    logic [14:0] plot_addr;

    assign plot_ok   = (32'(bus.vga_x) < FB_W) && (32'(bus.vga_y) < FB_H);
    assign plot_addr = 15'(bus.vga_y) * 15'(FB_W) + 15'(bus.vga_x);

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        raddr_d     = raddr_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_sof_d   = pix_sof_q;
        pix_eol_d   = pix_eol_q;
        we          = 1'b0;
        wa          = clr_addr_q;
        wd          = CLR_COLOUR;
        load        = 1'b0;
        case (state_q)
            S_CLEAR: begin
                we = 1'b1;
                if (clear) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    rx_d    = '0;
                    ry_d    = '0;
                    raddr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: begin
                if (bus.vga_plot && plot_ok) begin
                    we = 1'b1;
                    wa = plot_addr;
                    wd = bus.vga_colour;
                end
                if (clear) begin
                    state_d     = S_CLEAR;
                    clr_addr_d  = '0;
                    pix_valid_d = 1'b0;
                end else if (!pix_valid_q || bus.pix_ready) begin
                    // Load the pixel at the raster position, then step the raster.
                    load        = 1'b1;
                    pix_valid_d = 1'b1;
                    pix_x_d     = rx_q;
                    pix_y_d     = ry_q;
                    pix_sof_d   = (rx_q == 8'd0) && (ry_q == 7'd0);
                    pix_eol_d   = (rx_q == X_LAST);
                    raddr_d     = (raddr_q == LAST_ADDR) ? 15'd0 : raddr_q + 15'd1;
                    if (rx_q == X_LAST) begin
                        rx_d = '0;
                        ry_d = (ry_q == Y_LAST) ? 7'd0 : ry_q + 7'd1;
                    end else begin
                        rx_d = rx_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= '0;
            rx_q         <= '0;
            ry_q         <= '0;
            raddr_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_colour_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            raddr_q     <= raddr_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_sof_q   <= pix_sof_d;
            pix_eol_q   <= pix_eol_d;
            // Same-edge write to this address lands after the read: old value wins.
            if (load) begin
                pix_colour_q <= mem[raddr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst_n) begin
            mem[wa] <= wd;
        end
    end

`ifdef VGA_FB_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop = bus.vga_plot && ((state_q == S_CLEAR) || !plot_ok);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign busy           = (state_q == S_CLEAR);
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_sof    = pix_sof_q;
    assign bus.pix_eol    = pix_eol_q;
    assign bus.pix_colour = pix_colour_q;
endmodule

// File: tb/tb_vga_fb_scan.sv
// Self-checking bench for vga_fb_scan: directed scenarios plus random plots and
// backpressure, all compared against a linear-index framebuffer model.
module tb_vga_fb_scan;
    localparam int         W   = 160;
    localparam int         H   = 120;
    localparam int         N   = W * H;
    localparam logic [2:0] CLR = 3'b000;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busy;
`ifdef VGA_FB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    vga_fb_scan_if bus ();

    vga_fb_scan #(.FB_W(W), .FB_H(H), .CLR_COLOUR(CLR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .clear (clear),
        .busy  (busy)
`ifdef VGA_FB_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: framebuffer as a flat array, scanout as a linear pixel index.
    logic [2:0] fb [N];
    bit         m_run;
    int         m_clr;
    bit         m_valid;
    bit         m_sof;
    bit         m_eol;
    int         m_pix;
    logic [2:0] m_col;
    int         m_next;
    int         m_drops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit in_fb;
        int a;
        in_fb = (int'(bus.vga_x) < W) && (int'(bus.vga_y) < H);
        a     = int'(bus.vga_y) * W + int'(bus.vga_x);
        if (rst_n) begin
            m_run = 0; m_clr = 0; m_valid = 0; m_sof = 0; m_eol = 0;
            m_pix = 0; m_col = '0; m_next = 0; m_drops = 0;
        end else if (!m_run) begin
            if (bus.vga_plot && m_drops < 65535) m_drops++;
            if (clear) begin
                m_clr = 0;
                m_drops = 0;
            end else begin
                fb[m_clr] = CLR;
                if (m_clr == N - 1) begin
                    m_run = 1;
                    m_next = 0;
                end else begin
                    m_clr++;
                end
            end
        end else begin
            if (!clear && (!m_valid || bus.pix_ready)) begin
                m_pix   = m_next;
                m_col   = fb[m_next];
                m_valid = 1;
                m_sof   = (m_next == 0);
                m_eol   = (m_next % W == W - 1);
                m_next  = (m_next + 1) % N;
            end
            if (bus.vga_plot) begin
                if (in_fb) fb[a] = bus.vga_colour;
                else if (m_drops < 65535) m_drops++;
            end
            if (clear) begin
                m_run = 0; m_clr = 0; m_valid = 0; m_drops = 0;
            end
        end
    endtask

    task automatic compare();
        check("busy", busy, m_run ? 0 : 1);
        check("pix_valid", bus.pix_valid, m_valid);
        if (m_valid) begin
            check("pix_x", bus.pix_x, m_pix % W);
            check("pix_y", bus.pix_y, m_pix / W);
            check("pix_colour", bus.pix_colour, m_col);
            check("pix_sof", bus.pix_sof, m_sof);
            check("pix_eol", bus.pix_eol, m_eol);
        end
`ifdef VGA_FB_DROP_CNT_EN
        check("drop_cnt", drop_cnt, m_drops);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic rand_inputs(input bit plots);
        bus.vga_plot   = plots && ($urandom_range(0, 7) == 0);
        bus.vga_x      = 8'($urandom_range(0, 170));
        bus.vga_y      = 7'($urandom_range(0, 127));
        bus.vga_colour = 3'($urandom);
        bus.pix_ready  = ($urandom_range(0, 7) != 0);
    endtask

    task automatic wait_pix(input int idx, input int budget);
        int n;
        n = 0;
        while (!(m_valid && m_pix == idx) && n < budget) begin
            tick();
            n++;
        end
        check("wait_pix_in_budget", (n < budget) ? 1 : 0, 1);
    endtask

    task automatic plot(input int x, input int y, input logic [2:0] c);
        bus.vga_plot   = 1'b1;
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = c;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1; clear = 1'b0;
        bus.vga_plot = 1'b0; bus.vga_x = '0; bus.vga_y = '0;
        bus.vga_colour = '0; bus.pix_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_pix_sof", bus.pix_sof, 0);
        check("rst_pix_eol", bus.pix_eol, 0);
        check("rst_pix_colour", bus.pix_colour, 0);
        check("rst_pix_x", bus.pix_x, 0);
        check("rst_pix_y", bus.pix_y, 0);
        rst_n = 1'b0;

        // Initial fill: busy for exactly one cycle per pixel.
        cnt = 0;
        while (busy && cnt < N + 100) begin
            cnt++;
            tick();
        end
        check("clear_cycles", cnt, N);
        check("first_run_valid", bus.pix_valid, 0);

        bus.pix_ready = 1'b1;
        plot(20, 15, 3'b010);
        tick();
        check("first_pix_sof", bus.pix_sof, 1);
        check("first_pix_colour", bus.pix_colour, 0);
        plot(160, 15, 3'b111);
        tick();
        plot(5, 120, 3'b111);
        tick();
        bus.vga_plot = 1'b0;
`ifdef VGA_FB_DROP_CNT_EN
        check("drop_cnt_two", drop_cnt, 2);
`endif

        // Backpressure hold at (3,0).
        wait_pix(3, 10);
        bus.pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_x", bus.pix_x, 3);
            check("stall_valid", bus.pix_valid, 1);
        end
        bus.pix_ready = 1'b1;
        tick();
        check("after_stall_x", bus.pix_x, 4);

        // Plot into the pixel being loaded: old value out now, new one next frame.
        wait_pix(6, 10);
        plot(7, 0, 3'b100);
        tick();
        bus.vga_plot = 1'b0;
        check("rbw_x", bus.pix_x, 7);
        check("rbw_colour", bus.pix_colour, 0);

        wait_pix(15 * W + 20, N + 10);
        check("plotted_colour", bus.pix_colour, 3'b010);
        wait_pix(0, N + 10);
        check("frame2_sof", bus.pix_sof, 1);
        wait_pix(7, 20);
        check("frame2_rbw_colour", bus.pix_colour, 3'b100);

        // Random plots and backpressure.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1'b1);
            tick();
        end

        // Clear with plots arriving throughout, restart mid-fill, then reset mid-fill.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        check("busy_before_reset", busy, 1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        cnt = 0;
        while (busy && cnt < N + 100) begin
            rand_inputs(1'b1);
            cnt++;
            tick();
        end
        check("reclear_cycles", cnt, N);

        // Scan after the fill: model expects CLR_COLOUR everywhere.
        bus.vga_plot = 1'b0;
        for (int i = 0; i < 500; i++) begin
            bus.pix_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (m_valid) check("post_clear_colour", bus.pix_colour, CLR);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
